interpolator: RTL and testbench

Per-channel ×RATE upsampler for the sonar sample path. Each accepted 24-bit signed sample on a time-multiplexed, channel-tagged AXI-Stream input is expanded into RATE output beats on the same channel, either by repeating the sample or by zero-stuffing. It is the transmit-side counterpart of the ÷5 decimator. It sits between the waveform/DSP source and the DAC-side filter chain.

---
 rtl/interpolator.sv | 81 ++++++++
 tb/tb_interpolator.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interpolator.sv
// rtl/interpolator.sv - per-channel xRATE upsampler (repeat or zero-stuff) on a channel-tagged stream
module interpolator #(
  parameter int RATE       = 5,
  parameter bit ZERO_STUFF = 1'b0
) (
  input  logic        s_axis_aclk,
  input  logic        s_axis_areset,
  input  logic [23:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [2:0]  s_axis_tuser,
  input  logic        s_axis_tlast,
  output logic [23:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [2:0]  m_axis_tuser,
  output logic        m_axis_tlast
);

  localparam int PW = (RATE > 1) ? $clog2(RATE) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(RATE - 1);

  typedef enum logic {ST_IDLE, ST_EMIT} state_t;

  state_t        state;
  logic [23:0]   sample;
  logic [2:0]    chan;
  logic          last_flag;
  logic [PW-1:0] phase;
  logic          final_beat;
  logic          take_in;

  assign final_beat    = (state == ST_EMIT) && m_axis_tready && (phase == PH_LAST);
  // Ready is held low during reset so no beat can be accepted and lost.
  assign s_axis_tready = !s_axis_areset && ((state == ST_IDLE) || final_beat);
  assign take_in       = s_axis_tvalid && s_axis_tready;

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      state     <= ST_IDLE;
      sample    <= '0;
      chan      <= '0;
      last_flag <= 1'b0;
      phase     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take_in) begin
            sample    <= s_axis_tdata;
            chan      <= s_axis_tuser;
            last_flag <= s_axis_tlast;
            phase     <= '0;
            state     <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (m_axis_tready) begin
            if (phase != PH_LAST) begin
              phase <= phase + PW'(1);
            end else if (take_in) begin
              // Back-to-back: the next sample starts without an idle bubble.
              sample    <= s_axis_tdata;
              chan      <= s_axis_tuser;
              last_flag <= s_axis_tlast;
              phase     <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign m_axis_tvalid = (state == ST_EMIT);
  assign m_axis_tdata  = (!ZERO_STUFF || (phase == '0)) ? sample : 24'd0;
  assign m_axis_tuser  = chan;
  assign m_axis_tlast  = last_flag && (phase == PH_LAST) && (state == ST_EMIT);

endmodule

// File: tb/tb_interpolator.sv
// tb/tb_interpolator.sv - randomized bench for interpolator against a beat-queue reference model
module tb_interpolator;

  typedef struct {
    logic [23:0] data;
    logic [2:0]  user;
    logic        last;
    int          cyc;
  } beat_t;

  logic        clk;
  logic        rst;
  logic [23:0] s_tdata;
  logic [2:0]  s_tuser;
  logic        s_tlast;
  logic        s_tvalid [3];
  logic        s_tready [3];
  logic [23:0] m_tdata  [3];
  logic        m_tvalid [3];
  logic        m_tready [3];
  logic [2:0]  m_tuser  [3];
  logic        m_tlast  [3];

  int vectors = 0;
  int fails   = 0;
  int cyc     = 0;
  int bp [3];
  beat_t mq [3][$];
  beat_t lg [3][$];
  beat_t ref_lg [$];

  // Instance 0: RATE 5 repeat, 1: RATE 5 zero-stuff, 2: RATE 2 repeat.
  interpolator #(.RATE(5), .ZERO_STUFF(1'b0)) dut_rep (
    .s_axis_aclk(clk), .s_axis_areset(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready[0]),
    .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata[0]), .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready[0]),
    .m_axis_tuser(m_tuser[0]), .m_axis_tlast(m_tlast[0]));

  interpolator #(.RATE(5), .ZERO_STUFF(1'b1)) dut_zs (
    .s_axis_aclk(clk), .s_axis_areset(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready[1]),
    .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata[1]), .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready[1]),
    .m_axis_tuser(m_tuser[1]), .m_axis_tlast(m_tlast[1]));

  interpolator #(.RATE(2), .ZERO_STUFF(1'b0)) dut_r2 (
    .s_axis_aclk(clk), .s_axis_areset(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid[2]), .s_axis_tready(s_tready[2]),
    .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata[2]), .m_axis_tvalid(m_tvalid[2]), .m_axis_tready(m_tready[2]),
    .m_axis_tuser(m_tuser[2]), .m_axis_tlast(m_tlast[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rate_of(input int i);
    return (i == 2) ? 2 : 5;
  endfunction

  function automatic bit zs_of(input int i);
    return (i == 1);
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] @%0d: got %h expected %h", nm, i, cyc, act, exp);
    end
  endtask

  // Model: every accepted input becomes RATE queued beats; outputs and ready follow from queue depth.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        mq[i].delete();
        chk("rst_tvalid", i, 32'(m_tvalid[i]), 32'd0);
        chk("rst_tready", i, 32'(s_tready[i]), 32'd0);
        chk("rst_tdata",  i, 32'(m_tdata[i]),  32'd0);
        chk("rst_tuser",  i, 32'(m_tuser[i]),  32'd0);
        chk("rst_tlast",  i, 32'(m_tlast[i]),  32'd0);
      end else begin
        int n;
        bit exp_ready;
        beat_t b;
        n = mq[i].size();
        exp_ready = (n == 0) || (n == 1 && m_tready[i]);
        chk("tvalid", i, 32'(m_tvalid[i]), 32'(n > 0));
        chk("tready", i, 32'(s_tready[i]), 32'(exp_ready));
        if (n > 0) begin
          chk("tdata", i, 32'(m_tdata[i]), 32'(mq[i][0].data));
          chk("tuser", i, 32'(m_tuser[i]), 32'(mq[i][0].user));
          chk("tlast", i, 32'(m_tlast[i]), 32'(mq[i][0].last));
          if (m_tready[i]) begin
            b.data = m_tdata[i]; b.user = m_tuser[i]; b.last = m_tlast[i]; b.cyc = cyc;
            lg[i].push_back(b);
            void'(mq[i].pop_front());
          end
        end
        if (s_tvalid[i] && exp_ready) begin
          for (int k = 0; k < rate_of(i); k++) begin
            b.data = (zs_of(i) && k != 0) ? 24'd0 : s_tdata;
            b.user = s_tuser;
            b.last = s_tlast && (k == rate_of(i) - 1);
            b.cyc  = 0;
            mq[i].push_back(b);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++)
        m_tready[i] = ($urandom_range(99) < 32'(bp[i])) ? 1'b0 : 1'b1;
    end
  end

  task automatic send(input int i, input logic [23:0] d, input logic [2:0] u, input logic l);
    bit hs;
    int t;
    s_tdata = d; s_tuser = u; s_tlast = l; s_tvalid[i] = 1'b1;
    hs = 0; t = 0;
    while (!hs && t < 500) begin
      @(negedge clk);
      hs = s_tready[i];
      @(posedge clk);
      #1;
      t++;
    end
    if (!hs) begin
      fails++;
      $display("FAIL send_timeout[%0d]: got no handshake expected one within 500 cycles", i);
    end
    s_tvalid[i] = 1'b0;
  endtask

  task automatic drain(input int i);
    int t;
    t = 0;
    while (mq[i].size() != 0 && t < 1000) begin
      @(posedge clk);
      #2;
      t++;
    end
    if (mq[i].size() != 0) begin
      fails++;
      $display("FAIL drain_timeout[%0d]: got %0d beats pending expected 0", i, mq[i].size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 3; i++) lg[i].delete();
  endtask

  initial begin
    rst = 1'b1; s_tdata = '0; s_tuser = '0; s_tlast = 1'b0;
    for (int i = 0; i < 3; i++) begin s_tvalid[i] = 1'b0; m_tready[i] = 1'b1; bp[i] = 0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Repeat mode, single sample
    clear_logs();
    send(0, 24'h000123, 3'd2, 1'b0);
    drain(0);
    chk("t1_count", 0, 32'(lg[0].size()), 32'd5);
    foreach (lg[0][k]) begin
      chk("t1_data", 0, 32'(lg[0][k].data), 32'h000123);
      chk("t1_user", 0, 32'(lg[0][k].user), 32'd2);
      chk("t1_last", 0, 32'(lg[0][k].last), 32'd0);
    end

    // Zero-stuff mode with tlast
    clear_logs();
    send(1, 24'hFFFFFF, 3'd7, 1'b1);
    drain(1);
    chk("t2_count", 1, 32'(lg[1].size()), 32'd5);
    foreach (lg[1][k]) begin
      chk("t2_data", 1, 32'(lg[1][k].data), (k == 0) ? 32'h00FFFFFF : 32'd0);
      chk("t2_user", 1, 32'(lg[1][k].user), 32'd7);
      chk("t2_last", 1, 32'(lg[1][k].last), 32'(k == 4));
    end

    // Back-to-back on alternating channels
    clear_logs();
    for (int v = 1; v <= 4; v++) send(0, 24'(v), 3'((v - 1) % 2), 1'b0);
    drain(0);
    chk("t3_count", 0, 32'(lg[0].size()), 32'd20);
    if (lg[0].size() == 20) begin
      chk("t3_span", 0, 32'(lg[0][19].cyc - lg[0][0].cyc), 32'd19);
      foreach (lg[0][k]) begin
        chk("t3_data", 0, 32'(lg[0][k].data), 32'(k / 5 + 1));
        chk("t3_user", 0, 32'(lg[0][k].user), 32'((k / 5) % 2));
      end
    end
    ref_lg = lg[0];

    // Same stream under ~30% backpressure
    clear_logs();
    bp[0] = 30;
    for (int v = 1; v <= 4; v++) send(0, 24'(v), 3'((v - 1) % 2), 1'b0);
    drain(0);
    bp[0] = 0;
    chk("t4_count", 0, 32'(lg[0].size()), 32'(ref_lg.size()));
    if (lg[0].size() == ref_lg.size()) begin
      foreach (lg[0][k]) begin
        chk("t4_data", 0, 32'(lg[0][k].data), 32'(ref_lg[k].data));
        chk("t4_user", 0, 32'(lg[0][k].user), 32'(ref_lg[k].user));
      end
    end

    // Reset in the middle of a burst
    clear_logs();
    send(0, 24'h000055, 3'd3, 1'b1);
    for (int t = 0; t < 50 && lg[0].size() < 2; t++) begin
      @(posedge clk);
      #3;
    end
    rst = 1'b1;
    #1;
    chk("t5_async_tvalid", 0, 32'(m_tvalid[0]), 32'd0);
    chk("t5_async_tdata",  0, 32'(m_tdata[0]),  32'd0);
    chk("t5_async_tlast",  0, 32'(m_tlast[0]),  32'd0);
    chk("t5_async_tready", 0, 32'(s_tready[0]), 32'd0);
    chk("t5_beats_before", 0, 32'(lg[0].size()), 32'd2);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_logs();
    send(0, 24'h7FFFFF, 3'd1, 1'b1);
    drain(0);
    chk("t5_count", 0, 32'(lg[0].size()), 32'd5);
    foreach (lg[0][k]) begin
      chk("t5_data", 0, 32'(lg[0][k].data), 32'h007FFFFF);
      chk("t5_last", 0, 32'(lg[0][k].last), 32'(k == 4));
    end

    // RATE=2 corner, two samples to exercise the phase wrap
    clear_logs();
    send(2, 24'h0ABCDE, 3'd5, 1'b1);
    send(2, 24'h800000, 3'd6, 1'b1);
    drain(2);
    chk("t6_count", 2, 32'(lg[2].size()), 32'd4);
    if (lg[2].size() == 4) begin
      chk("t6_d0", 2, 32'(lg[2][0].data), 32'h000ABCDE);
      chk("t6_d3", 2, 32'(lg[2][3].data), 32'h00800000);
      chk("t6_l0", 2, 32'(lg[2][0].last), 32'd0);
      chk("t6_l1", 2, 32'(lg[2][1].last), 32'd1);
      chk("t6_u2", 2, 32'(lg[2][2].user), 32'd6);
    end

    // Randomized traffic with gaps and backpressure
    for (int i = 1; i < 3; i++) begin
      bp[i] = 30;
      for (int n = 0; n < 30; n++) begin
        if ($urandom_range(3) == 0) begin
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
        send(i, 24'($urandom), 3'($urandom_range(7)), 1'($urandom_range(1)));
      end
      drain(i);
      bp[i] = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no completion expected finish before 3000000");
    $fatal(1);
  end

endmodule
